// File: rtl/mem_bridge_pkg.sv
// Shared SPI SRAM bridge definitions: serial opcodes, frame size, FSM states.
// Also carries the byte-order helper used on both the TX and RX data paths.
`timescale 1ns/1ps
package mem_bridge_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         FRAME_BITS    = 64;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, FAULT} bridge_state_t;

  // The wire carries word bits [7:0] first, so data goes out byte-reversed.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shifter: runs one 64-bit frame in 128*CLK_DIV cycles after start and pulses done
// in the last cycle. It has no backpressure; start is only honoured between frames by the caller.
`timescale 1ns/1ps
module spi_shift_engine
  import mem_bridge_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_frame,
  output logic                  done,
  output logic [31:0]           rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int               DIV_W    = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);

  logic                  active;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic [6:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [31:0]           rx_sr;

  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign done    = active && (div_cnt == DIV_LAST) && (bit_cnt == 7'd63);
  assign mosi    = tx_sr[FRAME_BITS-1];
  assign rx_data = rx_sr;

  // Only the last 32 sampled bits (the data phase) are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= tx_frame;
      rx_sr   <= '0;
      sclk    <= 1'b0;
    end else if (active) begin
      div_cnt <= div_nxt;
      sclk    <= (div_nxt >= DIV_HALF);
      if (div_nxt == DIV_HALF) begin
        rx_sr <= {rx_sr[30:0], miso};
      end
      if (div_cnt == DIV_LAST) begin
        tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 7'd1;
        if (bit_cnt == 7'd63) begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// CPU mem_ce/mem_busy/mem_valid responder doing one 32-bit SPI SRAM access per request;
// mem_valid follows acceptance by 2+128*CLK_DIV cycles, and mem_busy is the CPU's only stall.
`timescale 1ns/1ps
module spi_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int ADDR_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_busy,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_fault,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  bridge_state_t         state;
  bridge_state_t         next_state;
  logic                  armed;
  logic                  req_we;
  logic                  accept;
  logic                  bad_addr;
  logic                  start;
  logic                  done;
  logic [31:0]           rx_data;
  logic [FRAME_BITS-1:0] tx_frame;

  assign accept   = (state == IDLE) && !mem_ce && armed;
  assign bad_addr = (mem_addr[1:0] != 2'b00) || ((mem_addr >> ADDR_BITS) != 32'h0);
  assign start    = accept && !bad_addr;

  // Address and write data are captured directly into the engine's frame register.
  assign tx_frame = {mem_we ? SPI_CMD_WRITE : SPI_CMD_READ,
                     mem_addr[23:0],
                     mem_we ? byte_swap(mem_wdata) : 32'h0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = bad_addr ? FAULT : SHIFT;
      SHIFT:   if (done) next_state = FINISH;
      FINISH:  next_state = IDLE;
      FAULT:   if (mem_ce) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so the pads never see decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b1;
      req_we    <= 1'b0;
      mem_busy  <= 1'b0;
      mem_valid <= 1'b0;
      mem_rdata <= 32'h0;
      mem_fault <= 1'b0;
      spi_cs_n  <= 1'b1;
    end else begin
      mem_busy  <= (next_state == SHIFT) || (next_state == FINISH);
      mem_fault <= (next_state == FAULT);
      spi_cs_n  <= (next_state != SHIFT);
      if (mem_ce) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end
      if (accept) begin
        req_we    <= mem_we;
        mem_valid <= 1'b0;
      end else if (state == FINISH) begin
        mem_valid <= 1'b1;
      end
      if ((state == FINISH) && !req_we) begin
        mem_rdata <= byte_swap(rx_data);
      end
    end
  end

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_frame(tx_frame),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .miso    (spi_miso)
  );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: CLK_DIV=2 and CLK_DIV=1 instances share one behavioural SPI SRAM,
// with expected frames and read data queued at request time and compared at mem_valid.
`timescale 1ns/1ps
module tb_spi_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        miso = 1'b0;

  logic        busy1, valid1, fault1, sclk1, cs1, mosi1;
  logic        busy2, valid2, fault2, sclk2, cs2, mosi2;
  logic [31:0] rdata1, rdata2;

  wire ce1 = sel ? 1'b1 : ce;
  wire ce2 = sel ? ce : 1'b1;

  wire        o_busy  = sel ? busy2  : busy1;
  wire        o_valid = sel ? valid2 : valid1;
  wire        o_fault = sel ? fault2 : fault1;
  wire        o_sclk  = sel ? sclk2  : sclk1;
  wire        o_cs_n  = sel ? cs2    : cs1;
  wire        o_mosi  = sel ? mosi2  : mosi1;
  wire [31:0] o_rdata = sel ? rdata2 : rdata1;

  always #5 clk = ~clk;

  spi_mem_bridge #(.CLK_DIV(2), .ADDR_BITS(24)) dut (
    .clk(clk), .reset(reset), .mem_ce(ce1), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_busy(busy1), .mem_valid(valid1), .mem_rdata(rdata1),
    .mem_fault(fault1), .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1),
    .spi_miso(miso)
  );

  spi_mem_bridge #(.CLK_DIV(1), .ADDR_BITS(24)) dut_div1 (
    .clk(clk), .reset(reset), .mem_ce(ce2), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_busy(busy2), .mem_valid(valid2), .mem_rdata(rdata2),
    .mem_fault(fault2), .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_mosi(mosi2),
    .spi_miso(miso)
  );

  typedef struct {
    logic [63:0] frame;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI SRAM: samples MOSI on SCLK rise, updates MISO on SCLK fall.
  logic [7:0]  sram [0:1023];
  logic [63:0] cap;
  logic [31:0] dsh;
  int          rx_cnt;
  int          cs_falls = 0;

  initial begin
    logic       prev_cs;
    logic       prev_sclk;
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
    sram[10'h104] = 8'h11;
    sram[10'h105] = 8'h22;
    sram[10'h106] = 8'h33;
    sram[10'h107] = 8'h44;
    prev_cs   = 1'bx;
    prev_sclk = 1'bx;
    rx_cnt    = 0;
    cap       = '0;
    dsh       = '0;
    forever begin
      @(o_sclk or o_cs_n);
      if (prev_cs === 1'b1 && o_cs_n === 1'b0) begin
        rx_cnt = 0;
        cap    = '0;
        cs_falls++;
      end
      if (o_cs_n !== 1'b0) miso = 1'b0;
      if (o_cs_n === 1'b0 && prev_sclk === 1'b0 && o_sclk === 1'b1) begin
        cap = {cap[62:0], o_mosi};
        rx_cnt++;
        if (rx_cnt == 32) begin
          a   = cap[9:0];
          dsh = {sram[a], sram[a + 10'd1], sram[a + 10'd2], sram[a + 10'd3]};
        end
        if (rx_cnt == 64 && cap[63:56] == 8'h02) begin
          a = cap[41:32];
          sram[a]         = cap[31:24];
          sram[a + 10'd1] = cap[23:16];
          sram[a + 10'd2] = cap[15:8];
          sram[a + 10'd3] = cap[7:0];
        end
      end
      if (o_cs_n === 1'b0 && prev_sclk === 1'b1 && o_sclk === 1'b0) begin
        if (rx_cnt >= 32 && rx_cnt < 64) miso = dsh[63 - rx_cnt];
      end
      prev_cs   = o_cs_n;
      prev_sclk = o_sclk;
    end
  end

  task automatic do_access(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                           input logic [63:0] ef, input logic [31:0] er,
                           input string tag, input bit release_ce);
    exp_t e;
    int   n;
    e.frame = ef;
    e.rdata = er;
    e.lat   = 2 + 128 * (sel ? 1 : 2);
    exp_q.push_back(e);
    @(negedge clk);
    ce = 1'b0; we = w; addr = ad; wdata = wd;
    @(posedge clk); #1;
    check({tag, ".busy_t1"}, o_busy, 1);
    check({tag, ".cs_t1"}, o_cs_n, 0);
    check({tag, ".mosi_t1"}, o_mosi, ef[63]);
    check({tag, ".valid_t1"}, o_valid, 0);
    n = 1;
    while (o_valid !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    check({tag, ".latency"}, n, e.lat);
    check({tag, ".busy_end"}, o_busy, 0);
    check({tag, ".rdata"}, o_rdata, e.rdata);
    check({tag, ".frame"}, cap, e.frame);
    if (release_ce) begin
      @(negedge clk);
      ce = 1'b1;
    end
  endtask

  task automatic fault_access(input logic [31:0] ad, input string tag);
    int f0;
    f0 = cs_falls;
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = ad;
    @(posedge clk); #1;
    check({tag, ".fault_t1"}, o_fault, 1);
    check({tag, ".busy_t1"}, o_busy, 0);
    check({tag, ".cs_t1"}, o_cs_n, 1);
    repeat (5) @(posedge clk);
    #1;
    check({tag, ".fault_hold"}, o_fault, 1);
    check({tag, ".busy_hold"}, o_busy, 0);
    check({tag, ".no_frame"}, cs_falls, f0);
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk); #1;
    check({tag, ".fault_clr"}, o_fault, 0);
  endtask

  initial begin
    int f0;
    sel = 1'b0; ce = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy1, 0);
    check("rst.valid", valid1, 0);
    check("rst.rdata", rdata1, 0);
    check("rst.fault", fault1, 0);
    check("rst.sclk", sclk1, 0);
    check("rst.cs", cs1, 1);
    check("rst.mosi", mosi1, 0);
    check("rst.cs_div1", cs2, 1);
    @(negedge clk);
    reset = 1'b0;

    do_access(1'b0, 32'h104, 32'h0, 64'h03000104_00000000, 32'h44332211, "rd", 1'b1);
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 64'h02000010_EFBEADDE, 32'h44332211, "wr", 1'b1);
    do_access(1'b0, 32'h10, 32'h0, 64'h03000010_00000000, 32'hDEADBEEF, "rdback", 1'b1);

    fault_access(32'h0000_0102, "flt_align");
    fault_access(32'h0100_0000, "flt_range");

    do_access(1'b0, 32'h104, 32'h0, 64'h03000104_00000000, 32'h44332211, "rearm1", 1'b0);
    f0 = cs_falls;
    repeat (20) @(posedge clk);
    #1;
    check("rearm.no_refetch", cs_falls, f0);
    check("rearm.valid_hold", o_valid, 1);
    @(negedge clk);
    ce = 1'b1;
    do_access(1'b0, 32'h10, 32'h0, 64'h03000010_00000000, 32'hDEADBEEF, "rearm2", 1'b1);
    check("rearm.new_frame", cs_falls, f0 + 1);

    // Abort a read during SCLK period 30.
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = 32'h104;
    repeat (121) @(posedge clk);
    #1;
    check("abort.busy_before", o_busy, 1);
    reset = 1'b1;
    #1;
    check("abort.cs", o_cs_n, 1);
    check("abort.busy", o_busy, 0);
    check("abort.rdata", o_rdata, 0);
    check("abort.sclk", o_sclk, 0);
    @(negedge clk);
    reset = 1'b0;
    ce = 1'b1;
    do_access(1'b0, 32'h104, 32'h0, 64'h03000104_00000000, 32'h44332211, "post_rst", 1'b1);

    @(negedge clk);
    sel = 1'b1;
    do_access(1'b0, 32'h104, 32'h0, 64'h03000104_00000000, 32'h44332211, "div1", 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
